// File: rtl/aes_pipeline_stage8_final.sv
// aes_pipeline_stage8_final: AES round 10 (SubBytes, ShiftRows, AddRoundKey) on the
// counter-block and J0 states. The CB keystream encrypts the plaintext, a partial
// final block is masked, and E(K,J0) is held as the tag mask. Results go to GHASH
// through a single valid/ready register stage. Vectors use bit 0 = MSB, and byte n
// is bits [8n:8n+7].
module aes_pipeline_stage8_final #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_phase,
  input  logic             i_last,
  input  logic [0:127]     i_plain_text,
  input  logic [0:127]     i_aad,
  input  logic [0:127]     i_h,
  input  logic [0:127]     i_encrypted_cb,
  input  logic [0:127]     i_encrypted_j0,
  input  logic [0:127]     i_instance_size,
  input  logic [0:1407]    i_key_schedule,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2:0]       o_phase,
  output logic [0:127]     o_cipher_text,
  output logic [0:127]     o_aad,
  output logic [0:127]     o_h,
  output logic [0:127]     o_instance_size,
  output logic [0:127]     o_tag_mask,
  output logic             o_tag_mask_valid,
  output logic [CNT_W-1:0] o_block_count
);

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_H    = 3'd1,
    PH_J0   = 3'd2,
    PH_AAD  = 3'd3,
    PH_PT   = 3'd4,
    PH_LEN  = 3'd5
  } phase_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [0:127] KEEP_ALL = '1;

  logic [0:127] rkey;
  logic [0:127] ks;
  logic [0:127] ej0;
  logic [0:127] pt_keep;
  logic [0:127] ct_next;
  logic [6:0]   part_bits;
  logic         accept;
  logic         pt_out_hs;
  logic         key_unused;

  // Only the round-10 key is needed at this stage.
  assign rkey       = i_key_schedule[1280:1407];
  assign key_unused = ^i_key_schedule[0:1279];

  // Output byte n (row n%4, column n/4) is taken from column (n/4 + n%4) % 4 of
  // the same row, which folds ShiftRows into the S-box input selection.
  for (genvar n = 0; n < 16; n++) begin : g_byte
    localparam int SRC = 4 * (((n / 4) + (n % 4)) % 4) + (n % 4);
    assign ks[8*n +: 8]  = SBOX[i_encrypted_cb[8*SRC +: 8]] ^ rkey[8*n +: 8];
    assign ej0[8*n +: 8] = SBOX[i_encrypted_j0[8*SRC +: 8]] ^ rkey[8*n +: 8];
  end

  // len(C) mod 128 is the low 7 bits of the len(C) field.
  assign part_bits = i_instance_size[121:127];
  assign o_ready   = !o_valid || i_ready;
  assign accept    = i_valid && o_ready;
  assign pt_out_hs = o_valid && i_ready && (o_phase == PH_PT);

  // Ciphertext for a PT beat, keeping only the first m bits of a partial final block.
  always_comb begin
    pt_keep = '1;
    if (i_last && (part_bits != 7'd0)) pt_keep = ~(KEEP_ALL >> part_bits);
    ct_next = '0;
    if (i_phase == PH_PT) ct_next = (i_plain_text ^ ks) & pt_keep;
  end

  // Output register stage, tag-mask latch and PT block counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid          <= 1'b0;
      o_phase          <= '0;
      o_cipher_text    <= '0;
      o_aad            <= '0;
      o_h              <= '0;
      o_instance_size  <= '0;
      o_tag_mask       <= '0;
      o_tag_mask_valid <= 1'b0;
      o_block_count    <= '0;
    end else begin
      if (accept) begin
        o_valid         <= 1'b1;
        o_phase         <= i_phase;
        o_cipher_text   <= ct_next;
        o_aad           <= i_aad;
        o_h             <= i_h;
        o_instance_size <= i_instance_size;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      // A J0 accept overrides a PT handshake in the same cycle.
      if (accept && (i_phase == PH_J0)) begin
        o_tag_mask       <= ej0;
        o_tag_mask_valid <= 1'b1;
        o_block_count    <= '0;
      end else if (pt_out_hs) begin
        o_block_count <= o_block_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_pipeline_stage8_final.sv
// Bench for aes_pipeline_stage8_final: FIPS-197 C.1 vector table, hand-written
// back-pressure / J0 / reset sequences, and randomized traffic. Everything is
// checked against a reference model that derives the S-box from GF(2^8) inversion.
module tb_aes_pipeline_stage8_final;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_valid, o_ready, i_last, o_valid, i_ready, o_tag_mask_valid;
  logic [2:0]       i_phase, o_phase;
  logic [0:127]     i_plain_text, i_aad, i_h, i_encrypted_cb, i_encrypted_j0, i_instance_size;
  logic [0:1407]    i_key_schedule;
  logic [0:127]     o_cipher_text, o_aad, o_h, o_instance_size, o_tag_mask;
  logic [CNT_W-1:0] o_block_count;

  always #5 clk = ~clk;

  aes_pipeline_stage8_final #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_phase(i_phase), .i_last(i_last), .i_plain_text(i_plain_text),
    .i_aad(i_aad), .i_h(i_h), .i_encrypted_cb(i_encrypted_cb),
    .i_encrypted_j0(i_encrypted_j0), .i_instance_size(i_instance_size),
    .i_key_schedule(i_key_schedule), .o_valid(o_valid), .i_ready(i_ready),
    .o_phase(o_phase), .o_cipher_text(o_cipher_text), .o_aad(o_aad), .o_h(o_h),
    .o_instance_size(o_instance_size), .o_tag_mask(o_tag_mask),
    .o_tag_mask_valid(o_tag_mask_valid), .o_block_count(o_block_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbt [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      b = b >> 1;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] aes_final(input logic [0:127] s, input logic [0:127] k);
    logic [7:0] sb [16];
    logic [7:0] kb [16];
    logic [0:127] ts = s, tk = k, out = '0;
    int r, c;
    for (int n = 0; n < 16; n++) begin
      sb[n] = ts[0:7]; kb[n] = tk[0:7];
      ts = ts << 8;    tk = tk << 8;
    end
    for (int n = 0; n < 16; n++) begin
      r = n % 4; c = n / 4;
      out = {out[8:127], sbt[sb[r + 4 * ((c + r) % 4)]] ^ kb[n]};
    end
    return out;
  endfunction

  logic             m_valid, m_tagv, last_acc;
  logic [2:0]       m_phase;
  logic [0:127]     m_ct, m_aad, m_h, m_len, m_tag;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_reset();
    m_valid = 0; m_tagv = 0; m_phase = 0; m_ct = '0; m_aad = '0;
    m_h = '0; m_len = '0; m_tag = '0; m_cnt = '0; last_acc = 0;
  endtask

  // One clock: check o_ready, advance the model across the edge, check outputs.
  task automatic cycle();
    logic exp_rdy, acc, hs, j0_acc, pt_hs;
    logic [0:127] ct;
    int m;
    #1;
    exp_rdy = !m_valid || i_ready;
    chk("o_ready", o_ready, exp_rdy);
    acc    = rst_n && i_valid && exp_rdy;
    hs     = m_valid && i_ready;
    j0_acc = acc && (i_phase == 3'd2);
    pt_hs  = hs && (m_phase == 3'd4);
    ct = '0;
    if (i_phase == 3'd4) begin
      ct = i_plain_text ^ aes_final(i_encrypted_cb, i_key_schedule[1280:1407]);
      m = int'(i_instance_size[64:127] % 128);
      if (i_last && m != 0)
        for (int i = m; i < 128; i++) ct[i] = 1'b0;
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      last_acc = acc;
      if (acc) begin
        m_valid = 1; m_phase = i_phase; m_ct = ct;
        m_aad = i_aad; m_h = i_h; m_len = i_instance_size;
      end else if (hs) begin
        m_valid = 0;
      end
      if (j0_acc) begin
        m_tag = aes_final(i_encrypted_j0, i_key_schedule[1280:1407]);
        m_tagv = 1; m_cnt = '0;
      end else if (pt_hs) begin
        m_cnt = m_cnt + 1;
      end
    end
    #1;
    chk("o_valid", o_valid, m_valid);
    chk("o_phase", o_phase, m_phase);
    chk("o_cipher_text", o_cipher_text, m_ct);
    chk("o_aad", o_aad, m_aad);
    chk("o_h", o_h, m_h);
    chk("o_instance_size", o_instance_size, m_len);
    chk("o_tag_mask", o_tag_mask, m_tag);
    chk("o_tag_mask_valid", o_tag_mask_valid, m_tagv);
    chk("o_block_count", o_block_count, m_cnt);
  endtask

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic [2:0] ph, input logic last, input logic [0:127] pt,
                       input logic [0:127] cb, input logic [0:127] j0, input logic [63:0] lenc);
    i_valid = 1; i_phase = ph; i_last = last; i_plain_text = pt;
    i_encrypted_cb = cb; i_encrypted_j0 = j0;
    i_instance_size = {64'($urandom) << 32 | 64'($urandom), lenc};
    i_aad = rand128(); i_h = rand128();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string        name;
    logic [2:0]   phase;
    logic         last;
    logic [0:127] pt, cb, j0;
    logic [63:0]  lenc;
    logic [0:127] exp_ct, exp_tag;
  } vec_t;

  localparam logic [0:127] C1_IN  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [0:127] C1_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [0:127] ONES   = '1;

  vec_t vt [7];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:127] jv;
    int cyc, tries;
    vt[0] = '{"c1_j0",      3'd2, 1'b0, '0,   '0,    C1_IN, 64'h0,   '0, C1_OUT};
    vt[1] = '{"c1_len",     3'd5, 1'b0, '0,   C1_IN, '0,    64'h0,   '0, C1_OUT};
    vt[2] = '{"c1_pt",      3'd4, 1'b0, '0,   C1_IN, '0,    64'h80,  C1_OUT, C1_OUT};
    vt[3] = '{"partial88",  3'd4, 1'b1, ONES, C1_IN, '0,    64'h58,
              128'h963b1f279584fbcf2732480000000000, C1_OUT};
    vt[4] = '{"last_full",  3'd4, 1'b1, '0,   C1_IN, '0,    64'h100, C1_OUT, C1_OUT};
    vt[5] = '{"nolast_88",  3'd4, 1'b0, ONES, C1_IN, '0,    64'h58,
              128'h963b1f279584fbcf2732487f8f4b3aa5, C1_OUT};
    vt[6] = '{"aad_pass",   3'd3, 1'b0, ONES, C1_IN, '0,    64'h58,  '0, C1_OUT};

    build_sbox();
    rst_n = 0; i_valid = 0; i_ready = 1; i_phase = 0; i_last = 0;
    i_plain_text = '0; i_aad = '0; i_h = '0; i_encrypted_cb = '0;
    i_encrypted_j0 = '0; i_instance_size = '0;
    for (int w = 0; w < 44; w++) i_key_schedule = {i_key_schedule[32:1407], 32'($urandom)};
    i_key_schedule[1280:1407] = C1_RK;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    i_valid = 1;                      // a beat offered during reset is dropped
    cycle();
    chk("reset_valid", o_valid, 1'b0);
    rst_n = 1; i_valid = 0;
    cycle();

    // table-driven FIPS-197 C.1 vectors
    for (int v = 0; v < 7; v++) begin
      drive(vt[v].phase, vt[v].last, vt[v].pt, vt[v].cb, vt[v].j0, vt[v].lenc);
      i_ready = 1;
      cycle();
      chk({vt[v].name, "_ct"}, o_cipher_text, vt[v].exp_ct);
      chk({vt[v].name, "_tag"}, o_tag_mask, vt[v].exp_tag);
      i_valid = 0;
      cycle();
      if (v == 2) chk("c1_pt_count", o_block_count, 1);
    end

    // back-pressure: 4 PT beats, i_ready low for the first 3 cycles
    drive(3'd2, 0, '0, '0, rand128(), 64'h0);
    cycle();
    i_valid = 0;
    cycle();
    cyc = 0;
    for (int b = 0; b < 4; b++) begin
      drive(3'd4, 0, rand128(), rand128(), '0, 64'h200);
      tries = 0;
      do begin
        i_ready = (cyc >= 3);
        cycle();
        cyc++; tries++;
      end while (!last_acc && tries < 20);
      if (!last_acc) chk("bp_accept_timeout", 1'b0, 1'b1);
    end
    i_valid = 0; i_ready = 1;
    cycle();
    cycle();
    chk("bp_count", o_block_count, 4);

    // PT, then J0 and PT back-to-back: J0 wins over the simultaneous PT handshake
    drive(3'd4, 0, rand128(), rand128(), '0, 64'h0);
    cycle();
    jv = rand128();
    drive(3'd2, 0, '0, '0, jv, 64'h0);
    cycle();
    chk("j0_sim_count", o_block_count, 0);
    drive(3'd4, 0, rand128(), rand128(), rand128(), 64'h0);
    cycle();
    i_valid = 0;
    cycle();
    chk("j0pt_count", o_block_count, 1);
    chk("j0pt_tag", o_tag_mask, aes_final(jv, C1_RK));

    // reset while a beat is stalled
    i_ready = 0;
    drive(3'd4, 0, rand128(), rand128(), '0, 64'h0);
    cycle();
    drive(3'd3, 0, rand128(), rand128(), '0, 64'h0);
    cycle();
    rst_n = 0;
    cycle();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_tagv", o_tag_mask_valid, 1'b0);
    chk("rst_count", o_block_count, 0);
    chk("rst_ct", o_cipher_text, '0);
    chk("rst_tag", o_tag_mask, '0);
    chk("rst_aad", o_aad, '0);
    rst_n = 1;
    cycle();
    i_valid = 0; i_ready = 1;
    cycle();

    // randomized traffic; inputs held while a beat is stalled
    for (int w = 0; w < 44; w++) i_key_schedule = {i_key_schedule[32:1407], 32'($urandom)};
    for (int t = 0; t < 400; t++) begin
      if (!i_valid || last_acc) begin
        logic [63:0] lenc;
        lenc = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) lenc[6:0] = 7'd0;
        drive(3'($urandom_range(0, 5)), 1'($urandom), rand128(), rand128(), rand128(), lenc);
        i_valid = ($urandom_range(0, 3) != 0);
      end
      i_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_pipeline_stage8_final.md
# aes_pipeline_stage8_final

Last stage of the AES-GCM encryption pipeline. It takes the round-9 state of the counter block (CB) and of J0 from the preceding stage and applies AES round 10: SubBytes, ShiftRows and AddRoundKey, with no MixColumns. It XORs the CB keystream with the plaintext, masks a partial final block, and latches E(K,J0) as the tag mask. Results go to the GHASH stage through a valid/ready register stage with back-pressure.

## Interface
Parameters:
- CNT_W, 32, width of the plaintext block counter

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- i_valid  in  1  upstream data valid
- o_ready  out  1  stage can accept this cycle
- i_phase  in  3  phase tag: 0 idle, 1 H, 2 J0, 3 AAD, 4 PT, 5 LEN
- i_last  in  1  current PT beat is the final plaintext block
- i_plain_text  in  128  plaintext block, bit 0 = MSB
- i_aad  in  128  AAD block, passed through
- i_h  in  128  hash subkey H, passed through
- i_encrypted_cb  in  128  CB state after round 9
- i_encrypted_j0  in  128  J0 state after round 9
- i_instance_size  in  128  [0:63] len(A) bits, [64:127] len(C) bits
- i_key_schedule  in  1408  expanded key, words 0..43; round-10 key = bits [1280:1407]
- o_valid  out  1  output register holds valid data
- i_ready  in  1  downstream accepts
- o_phase  out  3  registered phase
- o_cipher_text  out  128  masked ciphertext (PT phase), else 0
- o_aad, o_h, o_instance_size  out  128  registered pass-through
- o_tag_mask  out  128  held E(K,J0)
- o_tag_mask_valid  out  1  o_tag_mask loaded since last reset/J0
- o_block_count  out  CNT_W  PT blocks emitted since last J0

## Operation
- final_round(s, k) = AddRoundKey(ShiftRows(SubBytes(s)), k), with k = i_key_schedule[1280:1407]. Column-major byte order: byte n = bits [8n:8n+7]. ShiftRows rotates row r left by r.
- ks = final_round(i_encrypted_cb, k); ej0 = final_round(i_encrypted_j0, k).
- Accept happens when i_valid && o_ready. On accept the output register loads phase, pass-through fields and the ciphertext.
- Ciphertext loads only when phase==4; it is i_plain_text ^ ks. Otherwise the register loads 0.
- Partial block: when phase==4, i_last=1 and m = len(C) mod 128 ≠ 0, bits [m:127] of the ciphertext are forced to 0.
- Tag mask: on accept with phase==2, o_tag_mask <= ej0, o_tag_mask_valid <= 1 and o_block_count <= 0. o_tag_mask holds until the next J0 accept.
- Block counter: increments on each PT output handshake (o_valid && i_ready && o_phase==4). It wraps modulo 2^CNT_W.
- Simultaneous events: a J0 accept and a PT output handshake in the same cycle → counter = 0 (J0 wins).
- Phases 0, 1, 3, 5 pass through unmodified, with ciphertext 0.

## Timing
- Latency: 1 cycle, accept edge to o_valid.
- o_ready = !o_valid || i_ready, combinational. This gives full throughput of 1 block/cycle when i_ready=1.
- Stall: while o_valid && !i_ready, every output stays stable and o_ready=0.
- Upstream must hold i_* stable while i_valid && !o_ready.
- Reset (rst_n=0 at posedge) applies to every registered output:
  - o_valid=0, o_phase=0;
  - all 128-bit outputs = 0;
  - o_tag_mask_valid=0, o_block_count=0.
- Reset mid-stall discards the held beat. A beat presented on the reset cycle is not accepted.
- Combinational path per cycle: two parallel S-box/ShiftRows/XOR datapaths, plus the PT XOR and mask.

## Test plan
- FIPS-197 C.1 vector: key 000102…0f, round-9 state bd6e7c3df2b5779e0b61216e8b10b689, phase 5 → final_round output 69c4e0d86a7b0430d8cdb78070b4c55a. Drive it through both the CB and J0 paths (phase 2) and check o_tag_mask.
- PT beat: PT = 0, CB state as above → o_cipher_text = 69c4…c55a and o_block_count increments to 1 after the handshake.
- Partial block: len(C)=0x58 (88 bits), i_last=1, PT = all-ones → o_cipher_text bits [88:127] = 0 and bits [0:87] = ks ^ 1.
- Back-pressure: 4 PT beats with i_ready held 0 for 3 cycles → o_ready low and outputs stable while stalled; no beat lost or duplicated; o_block_count ends at 4.
- J0 then PT in back-to-back cycles with i_ready=1 → counter resets to 0, then reaches 1. o_tag_mask is unchanged by the PT beat.
- Reset during a stall → next cycle o_valid=0, o_tag_mask_valid=0, o_block_count=0, and all data outputs are 0.
